hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Stall and flush controller for the 5-stage pipeline.
//   Compares the D-stage source registers (Tuse) against E/M-stage producers (Tnew) and
//   decides when to freeze F and D and insert a bubble into D_E.
//   Owns the multi-cycle mult/div sequencer: tracks MDU busy time and stalls
//   MDU-dependent D instructions until it drains.
//   E_M and M_W are never stalled; their enables are tied on in this block.
// PARAMETERS
//   MULT_CYC  5   busy cycles for mult/multu (>=1)
//   DIV_CYC   10  busy cycles for div/divu (>=1)
//   CNT_W     4   MDU countdown width; must hold max(MULT_CYC,DIV_CYC)
//   PERF_W    32  width of stall-cycle performance counter
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   D_rs         in   5      D-stage rs index
//   D_rt         in   5      D-stage rt index
//   D_tuse_rs    in   2      cycles until rs needed (3 = not read)
//   D_tuse_rt    in   2      cycles until rt needed (3 = not read)
//   D_is_md      in   1      D instr uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
//   E_A3         in   5      E-stage destination register
//   E_tnew       in   2      cycles until E result available
//   E_Reg_Write  in   1      E instr writes GRF
//   M_A3         in   5      M-stage destination register
//   M_tnew       in   2      cycles until M result available
//   M_Reg_Write  in   1      M instr writes GRF
//   E_md_start   in   1      E instr launches MDU op (already qualified valid)
//   E_md_op      in   2      0 mult, 1 multu, 2 div, 3 divu
//   F_PC_WE      out  1      PC enable; 0 = hold
//   F_D_RegWE    out  1      F_D enable; 0 = hold
//   D_E_clear    out  1      1 = load bubble into D_E
//   E_M_RegWE    out  1      constant 1
//   M_W_RegWE    out  1      constant 1
//   M_W_clear    out  1      constant 0
//   md_busy      out  1      MDU sequencer occupied
//   md_done      out  1      high during last busy cycle
//   stall_cnt    out  PERF_W cycles with stall=1; saturating
// BEHAVIOUR
//   Data hazards
//   - hzE(r,t) = E_Reg_Write && E_A3!=0 && E_A3==r && t<E_tnew.
//   - hzM(r,t) is the same using the M_* ports.
//   - data_stall = hzE/hzM applied to (D_rs,D_tuse_rs) and (D_rt,D_tuse_rt).
//   MDU
//   - md_stall = D_is_md && (E_md_start || md_busy).
//   - stall = data_stall | md_stall.
//   Pipeline control (combinational)
//   - F_PC_WE = F_D_RegWE = ~stall; D_E_clear = stall.
//   - While reset is high: F_PC_WE=1, F_D_RegWE=1, D_E_clear=0.
//   Sequencer FSM
//   - IDLE: md_busy=0, cnt=0. On E_md_start, go to BUSY and load cnt:
//     mult/multu -> MULT_CYC, div/divu -> DIV_CYC.
//   - BUSY: md_busy=1; cnt decrements every cycle.
//     md_done=(cnt==1); when cnt==1, next state is IDLE.
//   - Timing: start sampled at edge t gives md_busy high for exactly N cycles after t.
//   - E_md_start while BUSY is ignored (prevented upstream by md_stall); no reload.
//   Perf counter
//   - stall_cnt += 1 each cycle stall=1 (reset low); holds at all-ones.
//   Reset
//   - reset (including mid-operation) forces IDLE, cnt=0, md_busy=0, md_done=0, stall_cnt=0.
//   - Takes effect on the next edge.
// STRUCTURE
//   - Shared header hazard_defs.vh: Tuse/Tnew encodings (TUSE_NONE=3), MD_MULT/MULTU/DIV/DIVU codes.
//   - Sub-module md_sequencer: FSM + countdown; outputs md_busy, md_done.
//   - Hazard compare and perf counter live in the top level.
// TESTING
//   1 E_A3=8,E_tnew=2,E_Reg_Write=1; D_rs=8,D_tuse_rs=1
//     -> F_PC_WE=0, D_E_clear=1 for 1 cycle.
//     Next cycle M_A3=8,M_tnew=1 -> stall=0.
//   2 Same as 1 but E_A3=0, or E_Reg_Write=0 -> stall=0; stall_cnt unchanged.
//   3 E_md_start,E_md_op=0 with D_is_md=1 held
//     -> stall for 1+5=6 cycles; md_done in 5th busy cycle; 7th cycle F_PC_WE=1.
//   4 E_md_op=2 start; reset in 4th busy cycle
//     -> next cycle md_busy=0, stall_cnt=0, D_E_clear=0.
//   5 E_md_start pulsed again in 2nd busy cycle of a div
//     -> busy still ends exactly 10 cycles after first start.
//   6 PERF_W=4, stall held 20 cycles -> stall_cnt reaches 15 and holds.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller.
//   - Tuse/Tnew encodings (TUSE_NONE marks an unread source)
//   - MDU operation codes and sequencer state type
//   - hazard compare helper used for every producer/consumer pair
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  // A producer blocks a consumer when it writes the same nonzero register and
  // its result arrives later than the consumer needs it. A TUSE_NONE source can
  // never be smaller than any Tnew, so unread sources drop out naturally.
  function automatic logic reg_hazard(input logic       we,
                                      input logic [4:0] a3,
                                      input logic [1:0] tnew,
                                      input logic [4:0] src,
                                      input logic [1:0] tuse);
    return we && (a3 != 5'd0) && (a3 == src) && (tuse < tnew);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
//   master : pipeline side; drives D/E/M stage info, receives enables/clears
//   slave  : controller side; the opposite directions
// PERF_W sets the width of the stall-cycle counter and must match the controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  logic [4:0]        D_rs;
  logic [4:0]        D_rt;
  logic [1:0]        D_tuse_rs;
  logic [1:0]        D_tuse_rt;
  logic              D_is_md;
  logic [4:0]        E_A3;
  logic [1:0]        E_tnew;
  logic              E_Reg_Write;
  logic [4:0]        M_A3;
  logic [1:0]        M_tnew;
  logic              M_Reg_Write;
  logic              E_md_start;
  logic [1:0]        E_md_op;

  logic              F_PC_WE;
  logic              F_D_RegWE;
  logic              D_E_clear;
  logic              E_M_RegWE;
  logic              M_W_RegWE;
  logic              M_W_clear;
  logic              md_busy;
  logic              md_done;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
           E_A3, E_tnew, E_Reg_Write, M_A3, M_tnew, M_Reg_Write,
           E_md_start, E_md_op,
    input  F_PC_WE, F_D_RegWE, D_E_clear, E_M_RegWE, M_W_RegWE, M_W_clear,
           md_busy, md_done, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
           E_A3, E_tnew, E_Reg_Write, M_A3, M_tnew, M_Reg_Write,
           E_md_start, E_md_op,
    output F_PC_WE, F_D_RegWE, D_E_clear, E_M_RegWE, M_W_RegWE, M_W_clear,
           md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_md_sequencer.sv
// Multi-cycle mult/div occupancy tracker.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : E-stage MDU launch (ignored while busy)
//   op         : MDU operation code, selects busy length
//   md_busy    : sequencer occupied
//   md_done    : high in the last busy cycle
// A start sampled at edge t keeps md_busy high for exactly N cycles after t.
module md_sequencer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  output logic       md_busy,
  output logic       md_done
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_busy = 1'b0;
    md_done = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_BUSY;
          cnt_d   = md_is_div(md_op_e'(op)) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end
      end
      SEQ_BUSY: begin
        // start is deliberately not looked at here: no reload while busy.
        md_busy = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          md_done = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave side of hazard_stall_ctrl_if
//     in : D-stage sources/Tuse, E/M destinations/Tnew/write enables, MDU start/op
//     out: F_PC_WE, F_D_RegWE (0 = hold), D_E_clear (bubble), E_M/M_W tie-offs,
//          md_busy, md_done, saturating stall_cnt
// E_M and M_W never stall, so their controls are constants here.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned PERF_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_stall_ctrl_if.slave   bus
);

  logic              data_stall;
  logic              md_stall;
  logic              stall;
  logic              md_busy;
  logic              md_done;
  logic [PERF_W-1:0] stall_cnt_q;

  md_sequencer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.E_md_start),
    .op      (bus.E_md_op),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  always_comb begin
    data_stall =
        reg_hazard(bus.E_Reg_Write, bus.E_A3, bus.E_tnew, bus.D_rs, bus.D_tuse_rs)
      | reg_hazard(bus.E_Reg_Write, bus.E_A3, bus.E_tnew, bus.D_rt, bus.D_tuse_rt)
      | reg_hazard(bus.M_Reg_Write, bus.M_A3, bus.M_tnew, bus.D_rs, bus.D_tuse_rs)
      | reg_hazard(bus.M_Reg_Write, bus.M_A3, bus.M_tnew, bus.D_rt, bus.D_tuse_rt);
    // A launch in E occupies the MDU from the next edge, so it blocks D already.
    md_stall = bus.D_is_md && (bus.E_md_start || md_busy);
    stall    = data_stall | md_stall;
  end

  always_comb begin
    bus.F_PC_WE   = 1'b1;
    bus.F_D_RegWE = 1'b1;
    bus.D_E_clear = 1'b0;
    if (!reset) begin
      bus.F_PC_WE   = ~stall;
      bus.F_D_RegWE = ~stall;
      bus.D_E_clear = stall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign bus.E_M_RegWE = 1'b1;
  assign bus.M_W_RegWE = 1'b1;
  assign bus.M_W_clear = 1'b0;
  assign bus.md_busy   = md_busy;
  assign bus.md_done   = md_done;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;
  localparam int unsigned PW     = 4;
  localparam int unsigned CMAX   = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.PERF_W(PW)) bus ();

  hazard_stall_ctrl #(
    .MULT_CYC (MULT_N),
    .DIV_CYC  (DIV_N),
    .CNT_W    (4),
    .PERF_W   (PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: MDU occupancy as an absolute cycle window,
  // stall counter as a plain integer clipped at the maximum.
  int unsigned cyc      = 0;
  int unsigned busy_end = 0;
  int unsigned m_cnt    = 0;
  bit          model_on = 0;

  function automatic bit hz(bit we, int a3, int tnew, int r, int tuse);
    return we && a3 != 0 && a3 == r && tuse < tnew;
  endfunction

  function automatic bit m_busy();
    return cyc < busy_end;
  endfunction

  function automatic bit m_stall();
    bit d;
    d = hz(bus.E_Reg_Write, bus.E_A3, bus.E_tnew, bus.D_rs, bus.D_tuse_rs) ||
        hz(bus.E_Reg_Write, bus.E_A3, bus.E_tnew, bus.D_rt, bus.D_tuse_rt) ||
        hz(bus.M_Reg_Write, bus.M_A3, bus.M_tnew, bus.D_rs, bus.D_tuse_rs) ||
        hz(bus.M_Reg_Write, bus.M_A3, bus.M_tnew, bus.D_rt, bus.D_tuse_rt);
    return d || (bus.D_is_md && (bus.E_md_start || m_busy()));
  endfunction

  always @(posedge clk) begin
    bit s, b;
    s = m_stall();
    b = m_busy();
    cyc++;
    if (reset) begin
      model_on = 1;
      busy_end = cyc;
      m_cnt    = 0;
    end else begin
      if (bus.E_md_start && !b)
        busy_end = cyc + ((bus.E_md_op >= 2) ? DIV_N : MULT_N);
      if (s && m_cnt < CMAX) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      bit s, b;
      s = m_stall();
      b = m_busy();
      chk("F_PC_WE",   bus.F_PC_WE,   reset ? 1 : int'(!s));
      chk("F_D_RegWE", bus.F_D_RegWE, reset ? 1 : int'(!s));
      chk("D_E_clear", bus.D_E_clear, reset ? 0 : int'(s));
      chk("E_M_RegWE", bus.E_M_RegWE, 1);
      chk("M_W_RegWE", bus.M_W_RegWE, 1);
      chk("M_W_clear", bus.M_W_clear, 0);
      chk("md_busy",   bus.md_busy,   int'(b));
      chk("md_done",   bus.md_done,   int'(b && cyc == busy_end - 1));
      chk("stall_cnt", int'(bus.stall_cnt), int'(m_cnt));
    end
  end

  task automatic idle();
    bus.D_rs = 0; bus.D_rt = 0; bus.D_tuse_rs = TUSE_NONE; bus.D_tuse_rt = TUSE_NONE;
    bus.D_is_md = 0;
    bus.E_A3 = 0; bus.E_tnew = 0; bus.E_Reg_Write = 0;
    bus.M_A3 = 0; bus.M_tnew = 0; bus.M_Reg_Write = 0;
    bus.E_md_start = 0; bus.E_md_op = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    reset = 1;
    tick();
    // reset overrides a live hazard on the combinational controls
    bus.E_A3 = 8; bus.E_tnew = 2; bus.E_Reg_Write = 1; bus.D_rs = 8; bus.D_tuse_rs = 1;
    #1;
    chk("rst_F_PC_WE", bus.F_PC_WE, 1);
    chk("rst_D_E_clear", bus.D_E_clear, 0);
    chk("rst_md_busy", bus.md_busy, 0);
    idle();
    tick();
    reset = 0;
    chk("rst_stall_cnt", int'(bus.stall_cnt), 0);

    // 1: E producer ahead of consumer, then moves to M and resolves
    bus.E_A3 = 8; bus.E_tnew = 2; bus.E_Reg_Write = 1; bus.D_rs = 8; bus.D_tuse_rs = 1;
    #1;
    chk("t1_F_PC_WE", bus.F_PC_WE, 0);
    chk("t1_D_E_clear", bus.D_E_clear, 1);
    tick();
    bus.E_A3 = 0; bus.E_tnew = 0; bus.E_Reg_Write = 0;
    bus.M_A3 = 8; bus.M_tnew = 1; bus.M_Reg_Write = 1;
    #1;
    chk("t1_resolved", bus.F_PC_WE, 1);
    chk("t1_cnt", int'(bus.stall_cnt), 1);
    tick();

    // 2: $0 destination, no write, Tuse == Tnew: no stall
    idle();
    bus.E_A3 = 0; bus.E_tnew = 2; bus.E_Reg_Write = 1; bus.D_rs = 0; bus.D_tuse_rs = 1;
    tick();
    bus.E_A3 = 8; bus.E_Reg_Write = 0; bus.D_rs = 8;
    tick();
    bus.E_Reg_Write = 1; bus.D_tuse_rs = 2;
    #1;
    chk("t2_tuse_eq", bus.D_E_clear, 0);
    tick();
    chk("t2_cnt", int'(bus.stall_cnt), 1);
    // rt path through M stage
    idle();
    bus.D_rt = 9; bus.D_tuse_rt = 0; bus.M_A3 = 9; bus.M_tnew = 1; bus.M_Reg_Write = 1;
    #1;
    chk("t2_rt_m", bus.F_D_RegWE, 0);
    tick();
    idle();

    // 3: mult with dependent MDU instruction held in D
    do_reset();
    bus.D_is_md = 1; bus.E_md_start = 1; bus.E_md_op = 0;
    #1;
    chk("t3_start_stall", bus.F_PC_WE, 0);
    tick();
    bus.E_md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      chk("t3_busy", bus.md_busy, 1);
      chk("t3_done", bus.md_done, (i == 5) ? 1 : 0);
      chk("t3_stall", bus.F_PC_WE, 0);
      tick();
    end
    chk("t3_release", bus.F_PC_WE, 1);
    chk("t3_cnt", int'(bus.stall_cnt), 6);
    idle();

    // 4: reset during a div
    bus.E_md_start = 1; bus.E_md_op = 2;
    tick();
    bus.E_md_start = 0;
    tick(); tick(); tick();
    chk("t4_busy4", bus.md_busy, 1);
    reset = 1; bus.D_is_md = 1;
    #1;
    chk("t4_rst_clear", bus.D_E_clear, 0);
    tick();
    reset = 0;
    #1;
    chk("t4_busy", bus.md_busy, 0);
    chk("t4_cnt", int'(bus.stall_cnt), 0);
    chk("t4_clear", bus.D_E_clear, 0);
    idle();
    tick();

    // 5: second start inside a div must not extend it
    bus.E_md_start = 1; bus.E_md_op = 2;
    tick();
    bus.E_md_start = 0;
    tick();
    bus.E_md_start = 1; bus.E_md_op = 0;
    tick();
    bus.E_md_start = 0;
    n = 0;
    while (bus.md_busy && n < 20) begin
      n++;
      tick();
    end
    chk("t5_remaining_busy", n, 8);
    idle();
    tick();

    // 6: counter saturation
    do_reset();
    bus.E_A3 = 8; bus.E_tnew = 2; bus.E_Reg_Write = 1; bus.D_rs = 8; bus.D_tuse_rs = 0;
    repeat (10) tick();
    chk("t6_cnt10", int'(bus.stall_cnt), 10);
    repeat (10) tick();
    chk("t6_sat", int'(bus.stall_cnt), 15);
    idle();
    tick();
    chk("t6_hold", int'(bus.stall_cnt), 15);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
